fetch_instr: RTL and testbench

Instruction fetch and issue unit for the single-cycle R-type datapath. Holds a small program memory that the testbench or a loader writes, and a byte-addressed program counter. On `start` it streams 32-bit instruction words to the datapath's `instruccion` input over a valid/ready handshake. It stops at a halt word or at the end of memory.

---
 rtl/fetch_instr_if.sv | 22 ++
 rtl/fetch_instr.sv | 114 +++++++++++
 tb/tb_fetch_instr.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_instr_if.sv
// Issue-side handshake between fetch_instr and the datapath.
// Master drives the instruction word and its byte address; slave returns ready.
interface fetch_instr_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruccion;
    logic [31:0] pc;

    modport master (
        output instr_valid,
        output instruccion,
        output pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instruccion,
        input  pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_instr.sv
// Instruction fetch/issue unit: loadable program memory streamed out over valid/ready.
// Optional FETCH_SKIP_NOP_EN: all-zero words are skipped instead of issued.
module fetch_instr #(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    fetch_instr_if.master                bus,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned Aw       = $clog2(MEM_WORDS);
    localparam logic [31:0] MemBytes = 32'(MEM_WORDS) << 2;

`ifdef FETCH_SKIP_NOP_EN
    localparam bit SkipNop = 1'b1;
`else
    localparam bit SkipNop = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        busy_q, done_q;
    logic        mem_we;
    logic [31:0] rd_word;

    logic [31:0] mem [MEM_WORDS];

    // Program memory survives rst; writes only land while the unit is quiescent.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign rd_word = mem[pc_q[Aw+1:2]];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                mem_we = load_en;
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                if (pc_q >= MemBytes) begin
                    state_d = StDone;
                end else begin
                    instr_d = rd_word;
                    // Decide offer-or-not here so instr_valid is a plain register.
                    valid_d = (rd_word != HALT_WORD) && !(SkipNop && (rd_word == '0));
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (valid_q) begin
                    if (bus.instr_ready) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + 32'd4;
                        state_d = StFetch;
                    end
                end else if (instr_q == HALT_WORD) begin
                    state_d = StDone;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == StFetch) || (state_d == StIssue);
            done_q  <= (state_d == StDone);
        end
    end

    assign bus.instr_valid = valid_q;
    assign bus.instruccion = instr_q;
    assign bus.pc          = pc_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_fetch_instr.sv
// Self-checking bench for fetch_instr: table-driven programs plus hand-written corner cases,
// with a transfer scoreboard per DUT instance (64-word and 4-word memories).
module tb_fetch_instr;

    localparam logic [31:0] HALT = 32'hFC000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } xfer_t;

    typedef struct packed {
        logic [3:0][31:0] w;
        int               exp_x;
        int               exp_done;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic        load_en0, load_en1;
    logic [5:0]  load_addr0;
    logic [1:0]  load_addr1;
    logic [31:0] load_data0, load_data1;
    logic        busy0, busy1, done0, done1;

    fetch_instr_if bus0();
    fetch_instr_if bus1();

    fetch_instr #(.MEM_WORDS(64)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .load_en   (load_en0),
        .load_addr (load_addr0),
        .load_data (load_data0),
        .bus       (bus0),
        .busy      (busy0),
        .done      (done0)
    );

    fetch_instr #(.MEM_WORDS(4)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .load_en   (load_en1),
        .load_addr (load_addr1),
        .load_data (load_data1),
        .bus       (bus1),
        .busy      (busy1),
        .done      (done1)
    );

    int    checks = 0;
    int    errors = 0;
    int    xfer0  = 0;
    int    xfer1  = 0;
    xfer_t q0[$];
    xfer_t q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transfers complete on the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus0.instr_valid && bus0.instr_ready) begin
            xfer0++;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer0_unexpected: got pc %h word %h expected none",
                         bus0.pc, bus0.instruccion);
            end else begin
                xfer_t e;
                e = q0.pop_front();
                check("xfer0_pc", bus0.pc, e.pc);
                check("xfer0_word", bus0.instruccion, e.word);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.instr_valid && bus1.instr_ready) begin
            xfer1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer1_unexpected: got pc %h word %h expected none",
                         bus1.pc, bus1.instruccion);
            end else begin
                xfer_t e;
                e = q1.pop_front();
                check("xfer1_pc", bus1.pc, e.pc);
                check("xfer1_word", bus1.instruccion, e.word);
            end
        end
    end

    // Reference model: words offered in order until a halt (or end of the 4 entries).
    task automatic push_model(input int dut, input logic [3:0][31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (w[i] == HALT) break;
`ifdef FETCH_SKIP_NOP_EN
            if (w[i] == 32'h0) continue;
`endif
            if (dut == 0) q0.push_back('{pc: 32'(i * 4), word: w[i]});
            else          q1.push_back('{pc: 32'(i * 4), word: w[i]});
        end
    endtask

    task automatic load0(input logic [5:0] a, input logic [31:0] d);
        load_en0 = 1'b1; load_addr0 = a; load_data0 = d;
        @(posedge clk); #1;
        load_en0 = 1'b0;
    endtask

    task automatic start_wait0(input int exp_x, input int exp_done, input string nm);
        int n;
        int x;
        x = xfer0;
        bus0.instr_ready = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        check({nm, "_busy"}, 32'(busy0), 32'd1);
        n = 0;
        while (!done0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_done_edge"}, 32'(n), 32'(exp_done));
        check({nm, "_xfers"}, 32'(xfer0 - x), 32'(exp_x));
        check({nm, "_sb_empty"}, 32'(q0.size()), 32'd0);
    endtask

    task automatic run0(input vec_t v, input string nm);
        for (int i = 0; i < 4; i++) load0(6'(i), v.w[i]);
        push_model(0, v.w);
        start_wait0(v.exp_x, v.exp_done, nm);
    endtask

    task automatic wait_valid0(input string nm);
        int n;
        n = 0;
        while (!bus0.instr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_valid_seen"}, 32'(bus0.instr_valid), 32'd1);
    endtask

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   n;
        int   x;

        tbl[0] = '{w: {HALT, HALT, 32'h00A62022, 32'h00221820}, exp_x: 2, exp_done: 6};
        tbl[1] = '{w: {HALT, HALT, HALT, HALT}, exp_x: 0, exp_done: 2};
        tbl[2] = '{w: {HALT, HALT, HALT, 32'h11111111}, exp_x: 1, exp_done: 4};
        tbl[3] = '{w: {HALT, 32'h0F0F0F0F, 32'h12345678, 32'hAAAA5555}, exp_x: 3, exp_done: 8};
        tbl[4] = '{w: {HALT, HALT, HALT, 32'hFC000001}, exp_x: 1, exp_done: 4};

        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        load_en0 = 1'b0; load_en1 = 1'b0;
        load_addr0 = '0; load_addr1 = '0;
        load_data0 = '0; load_data1 = '0;
        bus0.instr_ready = 1'b0;
        bus1.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_valid", 32'(bus0.instr_valid), 32'd0);
        check("rst_instr", bus0.instruccion, 32'h0);
        check("rst_pc", bus0.pc, 32'h0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);

        // Zero word: issued normally, or skipped when the NOP-skip build is used.
        v = '{w: {HALT, HALT, HALT, 32'h0}, exp_x: 1, exp_done: 4};
`ifdef FETCH_SKIP_NOP_EN
        v.exp_x = 0;
`endif
        run0(v, "zero");
        check("zero_pc_end", bus0.pc, 32'h4);

        for (int i = 0; i < 5; i++) begin
            run0(tbl[i], $sformatf("tbl%0d", i));
        end

        // Backpressure; a load during ISSUE must not reach memory.
        load0(6'd0, 32'hDEADBEEF);
        load0(6'd1, HALT);
        q0.push_back('{pc: 32'h0, word: 32'hDEADBEEF});
        bus0.instr_ready = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_valid0("bp");
        for (int k = 0; k < 5; k++) begin
            load_en0 = (k == 0); load_addr0 = 6'd0; load_data0 = 32'h12345678;
            check($sformatf("bp_valid%0d", k), 32'(bus0.instr_valid), 32'd1);
            check($sformatf("bp_instr%0d", k), bus0.instruccion, 32'hDEADBEEF);
            check($sformatf("bp_pc%0d", k), bus0.pc, 32'h0);
            @(posedge clk); #1;
        end
        load_en0 = 1'b0;
        x = xfer0;
        bus0.instr_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 32'(bus0.instr_valid), 32'd0);
        n = 0;
        while (!done0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_done", 32'(done0), 32'd1);
        check("bp_one_xfer", 32'(xfer0 - x), 32'd1);
        q0.push_back('{pc: 32'h0, word: 32'hDEADBEEF});
        start_wait0(1, 4, "bp_rerun");

        // Reset while a word is being offered.
        v = '{w: {HALT, HALT, 32'h00A62022, 32'h00221820}, exp_x: 2, exp_done: 6};
        for (int i = 0; i < 4; i++) load0(6'(i), v.w[i]);
        push_model(0, v.w);
        bus0.instr_ready = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_valid0("mrst");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        check("mrst_valid", 32'(bus0.instr_valid), 32'd0);
        check("mrst_pc", bus0.pc, 32'h0);
        check("mrst_instr", bus0.instruccion, 32'h0);
        check("mrst_busy", 32'(busy0), 32'd0);
        check("mrst_done", 32'(done0), 32'd0);
        push_model(0, v.w);
        start_wait0(2, 6, "mrst_rerun");

        // Zero words inside a program.
        v = '{w: {HALT, 32'h0, 32'h0, 32'h00221820}, exp_x: 3, exp_done: 8};
`ifdef FETCH_SKIP_NOP_EN
        v.exp_x = 1;
`endif
        run0(v, "nops");

        // End of memory on the 4-word instance: no halt word present.
        v.w = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        for (int i = 0; i < 4; i++) begin
            load_en1 = 1'b1; load_addr1 = 2'(i); load_data1 = v.w[i];
            @(posedge clk); #1;
        end
        load_en1 = 1'b0;
        push_model(1, v.w);
        x = xfer1;
        bus1.instr_ready = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("eom_done_edge", 32'(n), 32'd9);
        check("eom_xfers", 32'(xfer1 - x), 32'd4);
        check("eom_sb_empty", 32'(q1.size()), 32'd0);
        check("eom_pc", bus1.pc, 32'h10);
        repeat (3) @(posedge clk);
        #1;
        check("eom_no_extra", 32'(xfer1 - x), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
